// File: rtl/immgen_pipe.sv
// Immediate generator with a 2-entry elastic output buffer (output reg + skid reg).
// One cycle latency when the output is empty; in_ready is registered and stays low while the skid entry is full.
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instr,
  input  logic [SEL_W-1:0] imm_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic             imm_err
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state, state_nxt;
  logic [31:0]     raw;
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  logic [XLEN-1:0] skid_imm;
  logic            skid_err;
  logic            accept, pop;
  logic            load_out, load_skid, shift_skid;

  // Every format is first built as a 32-bit value already sign-filled where needed;
  // zero-extended formats have raw[31]=0, so one signed widening covers XLEN=64.
  always_comb begin
    raw     = 32'b0;
    dec_err = 1'b0;
    case (imm_sel)
      SEL_W'(0): raw = {{20{instr[31]}}, instr[31:20]};
      SEL_W'(1): raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SEL_W'(2): raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SEL_W'(3): raw = {instr[31:12], 12'b0};
      SEL_W'(4): raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      SEL_W'(5): raw = {instr[31:12], 12'b0};
      SEL_W'(6): raw = {27'b0, instr[19:15]};
      SEL_W'(7): begin
        raw     = 32'(instr[20 +: SHW]);
        dec_err = (XLEN == 32) && instr[25];
      end
      default:   raw = 32'b0;
    endcase
  end

  assign dec_imm   = XLEN'($signed(raw));
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt  = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_nxt  = ONE;
          shift_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready resets low so nothing is taken until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_out  <= '0;
      imm_err  <= 1'b0;
      skid_imm <= '0;
      skid_err <= 1'b0;
    end else begin
      if (load_out) begin
        imm_out <= dec_imm;
        imm_err <= dec_err;
      end else if (shift_skid) begin
        imm_out <= skid_imm;
        imm_err <= skid_err;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_err <= dec_err;
      end
    end
  end

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: XLEN=32 and XLEN=64 instances driven by the same stimulus.
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] word;
  logic [2:0]  imm_sel;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, imm_err_a;
  logic [31:0] imm_out_a;
  logic        in_ready_b, out_valid_b, imm_err_b;
  logic [63:0] imm_out_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .SEL_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(word[31:7]), .imm_sel(imm_sel), .out_valid(out_valid_a), .out_ready(out_ready),
    .imm_out(imm_out_a), .imm_err(imm_err_a)
  );

  immgen_pipe #(.XLEN(64), .SEL_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(word[31:7]), .imm_sel(imm_sel), .out_valid(out_valid_b), .out_ready(out_ready),
    .imm_out(imm_out_b), .imm_err(imm_err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [2:0] s);
    in_valid = 1'b1;
    word     = w;
    imm_sel  = s;
  endtask

  // One transfer with out_ready high: the result is on the outputs one cycle later.
  task automatic vec(input string tag, input logic [31:0] w, input logic [2:0] s,
                     input logic [31:0] exp32, input logic err32,
                     input logic [63:0] exp64, input logic err64);
    drive(w, s);
    step();
    in_valid = 1'b0;
    check({tag, "_vld32"}, 64'(out_valid_a), 64'd1);
    check({tag, "_imm32"}, 64'(imm_out_a), 64'(exp32));
    check({tag, "_err32"}, 64'(imm_err_a), 64'(err32));
    check({tag, "_vld64"}, 64'(out_valid_b), 64'd1);
    check({tag, "_imm64"}, imm_out_b, exp64);
    check({tag, "_err64"}, 64'(imm_err_b), 64'(err64));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    word      = 32'h0;
    imm_sel   = 3'd0;
    out_ready = 1'b1;

    #2;
    check("rst_vld", 64'(out_valid_a), 64'd0);
    check("rst_imm", 64'(imm_out_a), 64'd0);
    check("rst_err", 64'(imm_err_a), 64'd0);
    check("rst_rdy", 64'(in_ready_a), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    check("rst_rdy_rel", 64'(in_ready_a), 64'd0);
    step();
    check("rdy_after_edge32", 64'(in_ready_a), 64'd1);
    check("rdy_after_edge64", 64'(in_ready_b), 64'd1);

    vec("i_m1",  32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    vec("b_m4",  32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    vec("lui",   32'h123450B7, 3'd5, 32'h12345000, 1'b0, 64'h00000000_12345000, 1'b0);
    vec("s_neg", 32'h80000F80, 3'd1, 32'hFFFFF81F, 1'b0, 64'hFFFFFFFF_FFFFF81F, 1'b0);
    vec("u_neg", 32'hFFFFF037, 3'd3, 32'hFFFFF000, 1'b0, 64'hFFFFFFFF_FFFFF000, 1'b0);
    vec("j_p8",  32'h0080006F, 3'd4, 32'h00000008, 1'b0, 64'h00000000_00000008, 1'b0);
    vec("csr",   32'h800F8000, 3'd6, 32'h0000001F, 1'b0, 64'h00000000_0000001F, 1'b0);
    vec("sh_ok", 32'h00300000, 3'd7, 32'h00000003, 1'b0, 64'h00000000_00000003, 1'b0);
    vec("sh_32", 32'h02500000, 3'd7, 32'h00000005, 1'b1, 64'h00000000_00000025, 1'b0);
    step();
    check("drain_vld", 64'(out_valid_a), 64'd0);

    // Back-pressure: A held, B in skid, C waits, then all three drain in order.
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'd0);
    step();
    drive(32'h123450B7, 3'd5);
    step();
    check("bp_hold_a", 64'(imm_out_a), 64'hFFFFFFFF);
    check("bp_rdy0", 64'(in_ready_a), 64'd0);
    drive(32'h0080006F, 3'd4);
    step();
    check("bp_still_a", 64'(imm_out_a), 64'hFFFFFFFF);
    check("bp_still_vld", 64'(out_valid_a), 64'd1);
    check("bp_still_rdy0", 64'(in_ready_a), 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_out_b", 64'(imm_out_a), 64'h12345000);
    check("bp_rdy1", 64'(in_ready_a), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_out_c", 64'(imm_out_a), 64'h00000008);
    check("bp_vld_c", 64'(out_valid_a), 64'd1);
    step();
    check("bp_empty", 64'(out_valid_a), 64'd0);

    // Flush while full with a new input offered in the same cycle.
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'd0);
    step();
    drive(32'h123450B7, 3'd5);
    step();
    drive(32'h0080006F, 3'd4);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_vld", 64'(out_valid_a), 64'd0);
    check("fl_rdy", 64'(in_ready_a), 64'd1);
    check("fl_keep", 64'(imm_out_a), 64'hFFFFFFFF);
    out_ready = 1'b1;
    step();
    check("fl_no_c1", 64'(out_valid_a), 64'd0);
    step();
    check("fl_no_c2", 64'(out_valid_b), 64'd0);

    // Asynchronous reset with both entries occupied.
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'd0);
    step();
    drive(32'h123450B7, 3'd5);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_vld32", 64'(out_valid_a), 64'd0);
    check("ar_imm32", 64'(imm_out_a), 64'd0);
    check("ar_imm64", imm_out_b, 64'd0);
    check("ar_rdy", 64'(in_ready_a), 64'd0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("ar_rdy_back", 64'(in_ready_a), 64'd1);
    check("ar_still_empty", 64'(out_valid_a), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
